// File: rtl/nmr_qsw_pkg.sv
// Shared definitions for the Q-switch enable window generator.
package nmr_qsw_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int ECHO_W_DEF = 10;

  // One-hot controller state encoding
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_WAIT_LOW  = 5'b00010,
    ST_WAIT_RISE = 5'b00100,
    ST_DELAY     = 5'b01000,
    ST_ENABLE    = 5'b10000
  } qsw_state_e;

endpackage

// File: rtl/nmr_dcnt.sv
// Loadable down-counter with a terminal-count flag (count == 1).
// Load wins over decrement; the count saturates at zero.
module nmr_dcnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, else decrement while above zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/nmr_qsw_en_wingen_multi.sv
// Q-switch enable window generator: serves a whole CPMG echo train per ARM.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for ARM; configuration latched on acceptance
// WAIT_LOW   | waiting for ACQ_WND low so an already-open window is skipped
// WAIT_RISE  | waiting for ACQ_WND high; loads the delay counter
// DELAY      | counting DLY_CYC before enabling the Q-switch
// ENABLE     | EN_QSW high until ACQ_WND_PULSED or timeout
//
// ACQ_WND is retimed by one register before the FSM sees it, so EN_QSW rises
// DLY_CYC+2 cycles after the first edge that samples the window high.
module nmr_qsw_en_wingen_multi
  import nmr_qsw_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ECHO_W = ECHO_W_DEF
) (
  input  logic              ADC_CLK,
  input  logic              RESET_n,
  input  logic              ARM,
  input  logic              ABORT,
  input  logic              ACQ_WND,
  input  logic              ACQ_WND_PULSED,
  input  logic [CNT_W-1:0]  DLY_CYC,
  input  logic [CNT_W-1:0]  TMO_CYC,
  input  logic [ECHO_W-1:0] N_ECHO,
  output logic              EN_QSW,
  output logic              BUSY,
  output logic              DONE,
  output logic              TIMEOUT,
  output logic [ECHO_W-1:0] ECHO_CNT
);

  qsw_state_e        state_q, state_d;
  logic              acq_q;
  logic [CNT_W-1:0]  dly_cfg_q, dly_cfg_d;
  logic [CNT_W-1:0]  tmo_cfg_q, tmo_cfg_d;
  logic [ECHO_W-1:0] n_cfg_q, n_cfg_d;
  logic [ECHO_W-1:0] echo_q, echo_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmo_flag_q, tmo_flag_d;

  logic              dly_load, dly_dec, dly_tc;
  logic              tmo_load, tmo_dec, tmo_tc;
  logic              tmo_hit;

  // Delay from window rise to enable
  nmr_dcnt #(.W(CNT_W)) u_dly_cnt (
    .clk_i      (ADC_CLK),
    .rst_n_i    (RESET_n),
    .load_i     (dly_load),
    .load_val_i (dly_cfg_q),
    .dec_i      (dly_dec),
    .tc_o       (dly_tc)
  );

  // Enable high-time limit; only counts cycles in which EN_QSW is actually high
  nmr_dcnt #(.W(CNT_W)) u_tmo_cnt (
    .clk_i      (ADC_CLK),
    .rst_n_i    (RESET_n),
    .load_i     (tmo_load),
    .load_val_i (tmo_cfg_q),
    .dec_i      (tmo_dec),
    .tc_o       (tmo_tc)
  );

  assign dly_dec = (state_q == ST_DELAY);
  assign tmo_dec = (state_q == ST_ENABLE) && en_q;

  // Next-state, configuration latch and registered-output logic
  always_comb begin
    state_d    = state_q;
    dly_cfg_d  = dly_cfg_q;
    tmo_cfg_d  = tmo_cfg_q;
    n_cfg_d    = n_cfg_q;
    echo_d     = echo_q;
    tmo_flag_d = tmo_flag_q;
    done_d     = 1'b0;
    dly_load   = 1'b0;
    tmo_load   = 1'b0;
    tmo_hit    = 1'b0;

    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ABORT alongside ARM drops the ARM
          if (ARM && !ABORT) begin
            dly_cfg_d  = DLY_CYC;
            tmo_cfg_d  = TMO_CYC;
            n_cfg_d    = N_ECHO;
            echo_d     = '0;
            tmo_flag_d = 1'b0;
            state_d    = ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!acq_q) begin
            state_d = ST_WAIT_RISE;
          end
        end
        ST_WAIT_RISE: begin
          if (acq_q) begin
            if (dly_cfg_q == '0) begin
              tmo_load = 1'b1;
              state_d  = ST_ENABLE;
            end else begin
              dly_load = 1'b1;
              state_d  = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (dly_tc) begin
            tmo_load = 1'b1;
            state_d  = ST_ENABLE;
          end
        end
        ST_ENABLE: begin
          tmo_hit = (tmo_cfg_q != '0) && en_q && tmo_tc;
          if (ACQ_WND_PULSED || tmo_hit) begin
            // A strobe in the same cycle as the timeout counts as a normal end
            if (!ACQ_WND_PULSED) begin
              tmo_flag_d = 1'b1;
            end
            echo_d = echo_q + ECHO_W'(1);
            if ((n_cfg_q != '0) && (echo_d == n_cfg_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_LOW;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    en_d   = (state_q == ST_ENABLE) && (state_d == ST_ENABLE);
    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration and output registers
  always_ff @(posedge ADC_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      acq_q      <= 1'b0;
      dly_cfg_q  <= '0;
      tmo_cfg_q  <= '0;
      n_cfg_q    <= '0;
      echo_q     <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acq_q      <= ACQ_WND;
      dly_cfg_q  <= dly_cfg_d;
      tmo_cfg_q  <= tmo_cfg_d;
      n_cfg_q    <= n_cfg_d;
      echo_q     <= echo_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign EN_QSW   = en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign TIMEOUT  = tmo_flag_q;
  assign ECHO_CNT = echo_q;

endmodule

// File: tb/tb_nmr_qsw_en_wingen_multi.sv
// Self-checking bench for the Q-switch enable window generator.
// Expected window timing comes from a window-level model: EN_QSW rises D+2
// cycles after the window is first sampled high and ends at the strobe or
// after T high cycles, whichever is first.
`timescale 1ns/1ps
module tb_nmr_qsw_en_wingen_multi;

  localparam int CNT_W  = 16;
  localparam int ECHO_W = 10;
  localparam int HMAX   = 16384;

  logic              ADC_CLK        = 1'b0;
  logic              RESET_n        = 1'b0;
  logic              ARM            = 1'b0;
  logic              ABORT          = 1'b0;
  logic              ACQ_WND        = 1'b0;
  logic              ACQ_WND_PULSED = 1'b0;
  logic [CNT_W-1:0]  DLY_CYC        = '0;
  logic [CNT_W-1:0]  TMO_CYC        = '0;
  logic [ECHO_W-1:0] N_ECHO         = '0;
  logic              EN_QSW;
  logic              BUSY;
  logic              DONE;
  logic              TIMEOUT;
  logic [ECHO_W-1:0] ECHO_CNT;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic en_hist   [HMAX];
  logic done_hist [HMAX];

  nmr_qsw_en_wingen_multi #(.CNT_W(CNT_W), .ECHO_W(ECHO_W)) dut (
    .ADC_CLK        (ADC_CLK),
    .RESET_n        (RESET_n),
    .ARM            (ARM),
    .ABORT          (ABORT),
    .ACQ_WND        (ACQ_WND),
    .ACQ_WND_PULSED (ACQ_WND_PULSED),
    .DLY_CYC        (DLY_CYC),
    .TMO_CYC        (TMO_CYC),
    .N_ECHO         (N_ECHO),
    .EN_QSW         (EN_QSW),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .TIMEOUT        (TIMEOUT),
    .ECHO_CNT       (ECHO_CNT)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  // Edge index: value of cyc after the posedge that produced the outputs
  always @(posedge ADC_CLK) cyc = cyc + 1;

  always @(negedge ADC_CLK) begin
    if (cyc < HMAX) begin
      en_hist[cyc]   = EN_QSW;
      done_hist[cyc] = DONE;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ADC_CLK);
    #1;
  endtask

  task automatic arm(input int d, input int t, input int n);
    DLY_CYC = CNT_W'(d);
    TMO_CYC = CNT_W'(t);
    N_ECHO  = ECHO_W'(n);
    ARM     = 1'b1;
    tick(1);
    ARM     = 1'b0;
    // Scramble config inputs: the train must run on the latched copy
    DLY_CYC = CNT_W'($urandom);
    TMO_CYC = CNT_W'($urandom);
    N_ECHO  = ECHO_W'($urandom);
  endtask

  // k = edge index at which ACQ_WND is first sampled high; strobe_at < 0 means none
  task automatic drive_window(input int pre_low, input int acq_len, input int strobe_at,
                              input int len, output int k);
    ACQ_WND        = 1'b0;
    ACQ_WND_PULSED = 1'b0;
    tick(pre_low);
    k = cyc + 1;
    for (int i = 0; i < len; i++) begin
      ACQ_WND        = (i < acq_len);
      ACQ_WND_PULSED = (strobe_at >= 0) && (i == strobe_at);
      tick(1);
    end
    ACQ_WND        = 1'b0;
    ACQ_WND_PULSED = 1'b0;
  endtask

  function automatic void model_window(input int k, input int d, input int t, input int strobe_at,
                                       output int rise, output int fall, output bit tmo);
    rise = k + d + 2;
    fall = (strobe_at >= 0) ? (k + strobe_at) : 32'h4000_0000;
    tmo  = 1'b0;
    if ((t != 0) && (rise + t < fall)) begin
      fall = rise + t;
      tmo  = 1'b1;
    end
  endfunction

  function automatic int meas_rise(input int from);
    if (from < 0) return -1;
    for (int c = from; c < cyc && c < HMAX; c++)
      if (en_hist[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int meas_fall(input int from);
    if (from < 0) return -1;
    for (int c = from; c < cyc && c < HMAX; c++)
      if (en_hist[c] !== 1'b1) return c;
    return -1;
  endfunction

  function automatic int count_done(input int a);
    int n;
    n = 0;
    for (int c = a; c < cyc && c < HMAX; c++)
      if (done_hist[c] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset;
    RESET_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({EN_QSW, BUSY, DONE, TIMEOUT} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0000", {EN_QSW, BUSY, DONE, TIMEOUT});
    end
    n_cmp++;
    if (ECHO_CNT !== '0) begin
      n_bad++;
      $display("FAIL reset_echo_cnt: got %0d required 0", ECHO_CNT);
    end
    RESET_n = 1'b1;
    tick(2);
    ABORT = 1'b1;
    tick(1);
    ABORT = 1'b0;
    n_cmp++;
    if ({DONE, BUSY} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_abort: got done/busy %b required 00", {DONE, BUSY});
    end
    tick(1);
  endtask

  task automatic test_single_window;
    int k, r, f, rx, fx;
    bit tx;
    arm(0, 0, 1);
    drive_window(3, 25, 20, 23, k);
    model_window(k, 0, 0, 20, rx, fx, tx);
    r = meas_rise(k);
    f = meas_fall(r);
    n_cmp++;
    if (r != rx) begin n_bad++; $display("FAIL single_rise: got %0d required %0d", r, rx); end
    n_cmp++;
    if (f != fx) begin n_bad++; $display("FAIL single_fall: got %0d required %0d", f, fx); end
    n_cmp++;
    if (ECHO_CNT !== ECHO_W'(1)) begin n_bad++; $display("FAIL single_echo: got %0d required 1", ECHO_CNT); end
    n_cmp++;
    if (count_done(k) != 1) begin n_bad++; $display("FAIL single_done_count: got %0d required 1", count_done(k)); end
    n_cmp++;
    if (done_hist[fx] !== 1'b1) begin n_bad++; $display("FAIL single_done_edge: got %b required 1", done_hist[fx]); end
    n_cmp++;
    if ({BUSY, TIMEOUT} !== 2'b00) begin n_bad++; $display("FAIL single_busy_tmo: got %b required 00", {BUSY, TIMEOUT}); end
  endtask

  task automatic test_train;
    int k, r, f, rx, fx, start, al;
    bit tx;
    start = cyc;
    arm(5, 0, 4);
    for (int w = 0; w < 4; w++) begin
      if (w == 1) arm(0, 3, 1);    // ignored mid-train
      al = (w == 2) ? 2 : 20;      // window 2 closes during DELAY
      drive_window(3, al, 12, 15, k);
      model_window(k, 5, 0, 12, rx, fx, tx);
      r = meas_rise(k);
      f = meas_fall(r);
      n_cmp++;
      if (r != rx) begin n_bad++; $display("FAIL train_rise w%0d: got %0d required %0d", w, r, rx); end
      n_cmp++;
      if (f != fx) begin n_bad++; $display("FAIL train_fall w%0d: got %0d required %0d", w, f, fx); end
      n_cmp++;
      if (ECHO_CNT !== ECHO_W'(w + 1)) begin n_bad++; $display("FAIL train_echo w%0d: got %0d required %0d", w, ECHO_CNT, w + 1); end
      n_cmp++;
      if (count_done(k) != ((w == 3) ? 1 : 0)) begin
        n_bad++; $display("FAIL train_done w%0d: got %0d required %0d", w, count_done(k), (w == 3) ? 1 : 0);
      end
    end
    n_cmp++;
    if ({BUSY, TIMEOUT} !== 2'b00) begin n_bad++; $display("FAIL train_end_busy_tmo: got %b required 00", {BUSY, TIMEOUT}); end
    n_cmp++;
    if (count_done(start) != 1) begin n_bad++; $display("FAIL train_done_total: got %0d required 1", count_done(start)); end
  endtask

  task automatic test_timeout;
    int k, r, f, rx, fx;
    bit tx;
    arm(0, 8, 2);
    for (int w = 0; w < 2; w++) begin
      drive_window(3, 5, -1, 13, k);
      model_window(k, 0, 8, -1, rx, fx, tx);
      r = meas_rise(k);
      f = meas_fall(r);
      n_cmp++;
      if (r != rx) begin n_bad++; $display("FAIL tmo_rise w%0d: got %0d required %0d", w, r, rx); end
      n_cmp++;
      if (f - r != fx - rx) begin n_bad++; $display("FAIL tmo_high_len w%0d: got %0d required %0d", w, f - r, fx - rx); end
      n_cmp++;
      if (TIMEOUT !== tx) begin n_bad++; $display("FAIL tmo_flag w%0d: got %b required %b", w, TIMEOUT, tx); end
      n_cmp++;
      if (ECHO_CNT !== ECHO_W'(w + 1)) begin n_bad++; $display("FAIL tmo_echo w%0d: got %0d required %0d", w, ECHO_CNT, w + 1); end
    end
    n_cmp++;
    if (count_done(k) != 1 || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL tmo_done: got done %0d busy %b required 1 0", count_done(k), BUSY);
    end
    // Strobe in the 8th high cycle: normal end, flag cleared by ARM and not set
    arm(0, 8, 1);
    drive_window(3, 5, 10, 13, k);
    model_window(k, 0, 8, 10, rx, fx, tx);
    r = meas_rise(k);
    f = meas_fall(r);
    n_cmp++;
    if (f != fx) begin n_bad++; $display("FAIL tmo_coincide_fall: got %0d required %0d", f, fx); end
    n_cmp++;
    if (TIMEOUT !== tx) begin n_bad++; $display("FAIL tmo_coincide_flag: got %b required %b", TIMEOUT, tx); end
  endtask

  task automatic test_preopen;
    int k, r, from, rx, fx;
    bit tx;
    ACQ_WND = 1'b1;
    tick(2);
    arm(2, 0, 1);
    from = cyc;
    ACQ_WND = 1'b1;
    tick(10);
    n_cmp++;
    if (meas_rise(from) != -1) begin n_bad++; $display("FAIL preopen_no_en: got rise %0d required none", meas_rise(from)); end
    n_cmp++;
    if (BUSY !== 1'b1) begin n_bad++; $display("FAIL preopen_busy: got %b required 1", BUSY); end
    drive_window(3, 4, 10, 13, k);
    model_window(k, 2, 0, 10, rx, fx, tx);
    r = meas_rise(from);
    n_cmp++;
    if (r != rx) begin n_bad++; $display("FAIL preopen_rise: got %0d required %0d", r, rx); end
    n_cmp++;
    if (meas_fall(r) != fx) begin n_bad++; $display("FAIL preopen_fall: got %0d required %0d", meas_fall(r), fx); end
  endtask

  task automatic test_abort_collision;
    int k, r, rx, fx, start, w;
    bit tx;
    start = cyc;
    arm(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_window(3, 6, 8, 11, k);
      model_window(k, 1, 0, 8, rx, fx, tx);
      r = meas_rise(k);
      n_cmp++;
      if (r != rx) begin n_bad++; $display("FAIL cont_rise w%0d: got %0d required %0d", i, r, rx); end
    end
    n_cmp++;
    if (ECHO_CNT !== ECHO_W'(3) || BUSY !== 1'b1 || count_done(start) != 0) begin
      n_bad++; $display("FAIL cont_state: got echo %0d busy %b done %0d required 3 1 0", ECHO_CNT, BUSY, count_done(start));
    end
    ACQ_WND = 1'b0;
    tick(3);
    ACQ_WND = 1'b1;
    w = 0;
    while (EN_QSW !== 1'b1 && w < 20) begin tick(1); w++; end
    n_cmp++;
    if (EN_QSW !== 1'b1) begin n_bad++; $display("FAIL abort_wait_en: got %b required 1 within 20 cycles", EN_QSW); end
    ABORT   = 1'b1;
    ARM     = 1'b1;
    DLY_CYC = '0;
    N_ECHO  = ECHO_W'(1);
    tick(1);
    ABORT   = 1'b0;
    ARM     = 1'b0;
    ACQ_WND = 1'b0;
    n_cmp++;
    if ({EN_QSW, DONE, BUSY} !== 3'b010) begin n_bad++; $display("FAIL abort_outputs: got en/done/busy %b required 010", {EN_QSW, DONE, BUSY}); end
    n_cmp++;
    if (ECHO_CNT !== ECHO_W'(3)) begin n_bad++; $display("FAIL abort_echo_hold: got %0d required 3", ECHO_CNT); end
    tick(2);
    n_cmp++;
    if ({DONE, BUSY} !== 2'b00) begin n_bad++; $display("FAIL abort_arm_dropped: got done/busy %b required 00", {DONE, BUSY}); end
  endtask

  task automatic test_random;
    int d, t, n, sa, al, len, k, r, f, rx, fx;
    bit tx, tmo_acc;
    for (int tr = 0; tr < 4; tr++) begin
      d       = $urandom_range(0, 6);
      t       = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      n       = $urandom_range(1, 3);
      tmo_acc = 1'b0;
      arm(d, t, n);
      for (int w = 0; w < n; w++) begin
        sa  = ((t != 0) && ($urandom_range(0, 2) == 0)) ? -1 : (d + 3 + $urandom_range(0, 12));
        al  = $urandom_range(1, 15);
        len = ((sa > d + 2 + t) ? sa : (d + 2 + t)) + 3;
        drive_window(3, al, sa, len, k);
        model_window(k, d, t, sa, rx, fx, tx);
        tmo_acc = tmo_acc | tx;
        r = meas_rise(k);
        f = meas_fall(r);
        n_cmp++;
        if (r != rx || f != fx) begin
          n_bad++;
          $display("FAIL rand_window t%0d w%0d (D=%0d T=%0d strobe=%0d): got rise %0d fall %0d required %0d %0d",
                   tr, w, d, t, sa, r, f, rx, fx);
        end
        n_cmp++;
        if (ECHO_CNT !== ECHO_W'(w + 1) || TIMEOUT !== tmo_acc) begin
          n_bad++;
          $display("FAIL rand_status t%0d w%0d: got echo %0d tmo %b required %0d %b", tr, w, ECHO_CNT, TIMEOUT, w + 1, tmo_acc);
        end
        n_cmp++;
        if (count_done(k) != ((w == n - 1) ? 1 : 0) || BUSY !== (w != n - 1)) begin
          n_bad++;
          $display("FAIL rand_done t%0d w%0d: got done %0d busy %b required %0d %b",
                   tr, w, count_done(k), BUSY, (w == n - 1) ? 1 : 0, (w != n - 1));
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int k, w, c0, s;
    arm(0, 0, 3);
    drive_window(3, 6, 8, 11, k);
    n_cmp++;
    if (ECHO_CNT !== ECHO_W'(1)) begin n_bad++; $display("FAIL arst_pre_echo: got %0d required 1", ECHO_CNT); end
    ACQ_WND = 1'b0;
    tick(3);
    ACQ_WND = 1'b1;
    w = 0;
    while (EN_QSW !== 1'b1 && w < 20) begin tick(1); w++; end
    n_cmp++;
    if (EN_QSW !== 1'b1) begin n_bad++; $display("FAIL arst_wait_en: got %b required 1 within 20 cycles", EN_QSW); end
    @(negedge ADC_CLK);
    #2;
    c0 = cyc;
    RESET_n = 1'b0;
    #1;
    n_cmp++;
    if ({EN_QSW, BUSY} !== 2'b00 || cyc != c0) begin
      n_bad++; $display("FAIL arst_immediate: got en/busy %b edges %0d required 00 with no edge", {EN_QSW, BUSY}, cyc - c0);
    end
    n_cmp++;
    if (ECHO_CNT !== '0) begin n_bad++; $display("FAIL arst_echo: got %0d required 0", ECHO_CNT); end
    tick(2);
    ACQ_WND = 1'b0;
    RESET_n = 1'b1;
    tick(2);
    s = cyc;
    ACQ_WND_PULSED = 1'b1;
    tick(1);
    ACQ_WND_PULSED = 1'b0;
    tick(4);
    n_cmp++;
    if (count_done(s) != 0 || {EN_QSW, BUSY} !== 2'b00) begin
      n_bad++; $display("FAIL arst_post_strobe: got done %0d en/busy %b required 0 00", count_done(s), {EN_QSW, BUSY});
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_train();
    test_timeout();
    test_preopen();
    test_abort_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nmr_qsw_en_wingen_multi.md
Name: nmr_qsw_en_wingen_multi

Overview:
- Parametrised successor of the Q-switch enable window generator for the NMR receive path.
- Serves a full CPMG echo train from one ARM command, not a single window.
- Per echo: asserts EN_QSW after a programmable delay from the ACQ_WND rising edge, and releases it on ACQ_WND_PULSED or on a programmable timeout.
- Sits between the pulse-program sequencer (window strobes) and the Q-switch driver; runs in the ADC clock domain.

Parameters:
- CNT_W, 16: width of the delay and timeout counters and of DLY_CYC/TMO_CYC.
- ECHO_W, 10: width of N_ECHO and ECHO_CNT.

Ports:
- ADC_CLK  in  1  ADC sample clock; all logic is on its rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- ARM  in  1  one-cycle start strobe; accepted only in IDLE.
- ABORT  in  1  synchronous abort; has priority over all other inputs.
- ACQ_WND  in  1  acquisition window level, synchronous to ADC_CLK.
- ACQ_WND_PULSED  in  1  end-of-window strobe, synchronous to ADC_CLK.
- DLY_CYC  in  CNT_W  cycles from ACQ_WND rise to EN_QSW assertion; latched on ARM.
- TMO_CYC  in  CNT_W  maximum EN_QSW high time in cycles; 0 disables the timeout; latched on ARM.
- N_ECHO  in  ECHO_W  windows per train; 0 means continuous until ABORT; latched on ARM.
- EN_QSW  out  1  Q-switch enable, registered.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the train completes or is aborted.
- TIMEOUT  out  1  sticky flag: at least one window was ended by timeout; cleared on ARM.
- ECHO_CNT  out  ECHO_W  windows completed in the current train; cleared on ARM.

Behaviour:
- Reset (RESET_n low, asynchronous): state IDLE; EN_QSW, BUSY, DONE, TIMEOUT and ECHO_CNT are all 0; latched configuration registers and counters are 0.
- All outputs are registered. DONE defaults to 0 in every cycle in which it is not explicitly pulsed.
- IDLE:
  - On ARM: latch DLY_CYC, TMO_CYC and N_ECHO; clear ECHO_CNT and TIMEOUT; go to WAIT_LOW.
  - With no ARM, all other inputs are ignored.
- WAIT_LOW: wait for ACQ_WND == 0, then go to WAIT_RISE. This makes a window already open at arm time not count.
- WAIT_RISE: when ACQ_WND == 1, load the delay counter with the latched DLY_CYC.
  - If DLY_CYC == 0, go directly to ENABLE.
  - Otherwise go to DELAY.
- DELAY: decrement the counter each cycle; go to ENABLE in the cycle the counter reaches 1.
  - ACQ_WND falling during DELAY does not cancel the window; the window is still served.
- EN_QSW timing:
  - EN_QSW is 1 in the first cycle after entering ENABLE; the registered output rises one cycle after the state change.
  - With DLY_CYC == 0: EN_QSW rises 2 cycles after the first cycle ACQ_WND is sampled high.
  - With DLY_CYC == D: EN_QSW rises D+2 cycles after that sample.
- ENABLE: hold EN_QSW = 1 and count its high cycles. The window ends on either of:
  - ACQ_WND_PULSED == 1 sampled; or
  - TMO_CYC != 0 and the high-cycle count reaches TMO_CYC. In that case TIMEOUT is set to 1.
  - If both occur in the same cycle, the end is treated as a normal end: TIMEOUT is not set.
- End of window:
  - EN_QSW = 0 in the next cycle and ECHO_CNT increments. At the 2^ECHO_W − 1 boundary ECHO_CNT wraps to 0; this is relevant only in continuous mode.
  - If N_ECHO != 0 and the new ECHO_CNT == N_ECHO: go to IDLE and pulse DONE.
  - Otherwise go to WAIT_LOW for the next echo.
- ACQ_WND_PULSED outside ENABLE is ignored.
- ABORT (any non-IDLE state): next cycle EN_QSW = 0, go to IDLE, pulse DONE; ECHO_CNT holds its value.
  - ABORT in IDLE has no effect.
  - ARM and ABORT in the same cycle: ABORT wins and ARM is dropped.
- ARM outside IDLE is ignored; the latched configuration does not change mid-train.
- Reset mid-train: EN_QSW drops to 0 immediately (asynchronous), and all state is discarded.

Decomposition:
- Shared package nmr_qsw_pkg holds:
  - the one-hot state encoding: IDLE, WAIT_LOW, WAIT_RISE, DELAY, ENABLE;
  - default widths CNT_W_DEF = 16 and ECHO_W_DEF = 10.
- One sub-module: nmr_dcnt, a loadable down-counter with a terminal-count flag.
  - Instantiated twice: once for the delay, once for the timeout.
  - The timeout instance loads TMO_CYC on ENABLE entry.

Test Plan:
1. Single window: reset, ARM with DLY=0, TMO=0, N=1; ACQ_WND low for 3 cycles, then high; ACQ_WND_PULSED pulsed 20 cycles later -> EN_QSW rises 2 cycles after the ACQ_WND sample, falls 1 cycle after the strobe; ECHO_CNT=1; DONE pulses once; BUSY low afterwards.
2. Delay and train: ARM with DLY=5, N=4, four ACQ_WND windows each ended by a strobe -> each EN_QSW rise is 7 cycles after the window rise; ECHO_CNT steps 1→4; DONE fires only after the 4th; TIMEOUT=0.
3. Timeout: ARM with TMO=8, N=2, no ACQ_WND_PULSED -> EN_QSW is high for exactly 8 cycles per window; TIMEOUT=1 after the first window; ECHO_CNT=2; DONE fires. A strobe coinciding with the 8th cycle in a rerun -> TIMEOUT stays 0.
4. Pre-open window: ACQ_WND already high at ARM -> no EN_QSW until ACQ_WND goes low and rises again.
5. Abort and collision: N=0 continuous mode for 3 windows, then ABORT during ENABLE with ARM asserted in the same cycle -> EN_QSW is 0 the next cycle; DONE pulses; ECHO_CNT holds 3; state is IDLE (the ARM is dropped).
6. Asynchronous reset: assert RESET_n low mid-ENABLE between clock edges -> EN_QSW, BUSY and ECHO_CNT go to 0 without waiting for a clock edge; a later ACQ_WND_PULSED produces no DONE.
